// File: rtl/dmem_block.sv
// dmem_block: 256 x 128-bit block data memory with fixed-latency valid/ready access.
// Optional DMEM_PERF_CNT_EN adds rd_cnt/wr_cnt completion counters.
module dmem_block #(
  parameter int unsigned LATENCY = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   r_addr,
  input  logic [7:0]   w_addr,
  input  logic [127:0] w_data,
  input  logic         r_valid,
  input  logic         w_valid,
  output logic [127:0] r_data,
`ifdef DMEM_PERF_CNT_EN
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt,
`endif
  output logic         r_ready,
  output logic         w_ready
);

  typedef enum logic [2:0] {IDLE, WBUSY, RBUSY, WDONE, RDONE} state_t;

  // Loading LATENCY (not LATENCY-1) leaves the FSM busy until edge k+LATENCY+1,
  // which is where the ready pulse must start.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY);

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     cnt;
  logic [7:0]     r_addr_q;
  logic [7:0]     w_addr_q;
  logic [127:0]   w_data_q;
  logic           busy_done;
  logic [127:0]   mem [256];

  assign busy_done = (cnt == 8'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (w_valid)      state_nxt = WBUSY;
        else if (r_valid) state_nxt = RBUSY;
      end
      WBUSY:   if (busy_done) state_nxt = WDONE;
      RBUSY:   if (busy_done) state_nxt = RDONE;
      WDONE:   state_nxt = IDLE;
      RDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are captured once at acceptance; inputs are ignored while busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= 8'd0;
      r_addr_q <= 8'd0;
      w_addr_q <= 8'd0;
      w_data_q <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (w_valid) begin
            w_addr_q <= w_addr;
            w_data_q <= w_data;
            cnt      <= CNT_LOAD;
          end else if (r_valid) begin
            r_addr_q <= r_addr;
            cnt      <= CNT_LOAD;
          end
        end
        WBUSY, RBUSY: if (!busy_done) cnt <= cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // Storage has no reset so contents survive rstn; a reset mid-write drops the update.
  always_ff @(posedge clk) begin
    if (state == WBUSY && busy_done) mem[w_addr_q] <= w_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            r_data <= 128'd0;
    else if (state == RBUSY && busy_done) r_data <= mem[r_addr_q];
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else if (busy_done) begin
      if (state == RBUSY) rd_cnt <= rd_cnt + 32'd1;
      if (state == WBUSY) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

  assign w_ready = (state == WDONE);
  assign r_ready = (state == RDONE);

endmodule
